count_pwm: RTL
==============

// Module: count_pwm
// PURPOSE
//  Downstream stage of the free-running up counter. Consumes its count bus and produces a
//  registered PWM waveform with period 2**WIDTH clocks.
//  Duty is loaded through a valid/ready handshake into a shadow register. The shadow value
//  takes effect only at the period boundary (count==0), so the output never glitches.
//  Also flags count-bus discontinuities, such as a counter reset or a skipped value.
// PARAMETERS
//  WIDTH  4  width of count; PWM period = 2**WIDTH cycles; duty range 0..2**WIDTH
// PORTS
//  clk           in   1        clock; same clock as the upstream counter
//  rst           in   1        reset, asynchronous, active-low
//  count         in   WIDTH    upstream counter value, expected to increment by 1 per clk and wrap
//  duty_in       in   WIDTH+1  requested high-time in cycles per period
//  duty_valid    in   1        duty_in is valid
//  duty_ready    out  1        block can accept duty_in this cycle
//  pwm_out       out  1        PWM output, registered
//  period_start  out  1        1-cycle pulse aligned with the first pwm_out cycle of each active period
//  sync_err      out  1        sticky count-discontinuity flag
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; pwm_out=0; period_start=0; sync_err=0; duty_ready=1.
//   - active/shadow duty = 0; prev_count = 0; prev_vld = 0.
//  Boundary: cycle in which sampled count==0.
//  Handshake:
//   - duty_ready = (state==IDLE || state==RUN), decoded from state.
//   - Accept on the rising clk edge where duty_valid && duty_ready.
//   - Accepted value goes to shadow; values > 2**WIDTH clamp to 2**WIDTH.
//   - duty_in is ignored when not accepted. duty_valid may drop without being accepted.
//  States:
//   - IDLE: no duty loaded; pwm_out=0. Accept -> ARMED.
//   - ARMED: duty_ready=0. At boundary: active<=shadow, go to RUN.
//   - RUN: duty_ready=1. Accept -> UPDATE.
//   - UPDATE: duty_ready=0. At boundary: active<=shadow, go to RUN.
//   - An accept in a boundary cycle (IDLE or RUN) is applied at the NEXT boundary, not the current one.
//  Output, 1-cycle latency from count:
//   - RUN/UPDATE, or ARMED at a boundary: pwm_out <= (count < eff_duty).
//   - eff_duty = shadow when loading this cycle, otherwise active.
//   - Compare is unsigned, WIDTH+1 bits.
//   - Duty 0: pwm_out constantly 0. Duty 2**WIDTH: constantly 1.
//   - IDLE, or ARMED off-boundary: pwm_out <= 0.
//  period_start: registered; <= boundary && next state is RUN or UPDATE.
//  sync_err:
//   - prev_count <= count every cycle; prev_vld <= 1 one cycle after reset release.
//   - Set when prev_vld && count != prev_count+1 (mod 2**WIDTH).
//   - Sticky; cleared only by rst. Does not alter the PWM or FSM.
//  Reset mid-operation: all state discarded immediately, including pending shadow; outputs go to reset values.
// TESTING (WIDTH=4, period 16, counter and block share rst)
//  1. Reset release, duty 5 offered at cycle 3
//     -> accepted; no pwm until first count==0.
//     -> Then pwm_out high 5 clocks, low 11, repeating; period_start on the first high.
//  2. Running with duty 5; offer duty 12 mid-period
//     -> ready drops to 0; current period stays at 5 high.
//     -> Next period 12 high/4 low; ready returns to 1.
//  3. Duty 0 and duty 16 (also offer 20)
//     -> pwm constantly 0, then constantly 1; 20 clamps to 16 (constantly 1).
//  4. Offer duty 9 exactly in a count==0 cycle while in RUN with duty 3
//     -> that period stays at 3 high; 9 applies from the following period.
//  5. Skip: drive count 7 -> 9 (force)
//     -> sync_err=1 next cycle and remains set; pwm unaffected; cleared only by rst pulse.
//  6. Assert rst in UPDATE with pwm_out=1
//     -> pwm_out=0, duty_ready=1, sync_err=0 asynchronously; pending duty discarded.

Source files
------------

// File: rtl/count_pwm.sv
// count_pwm: registered PWM from an upstream count bus, shadowed duty load at count==0, sticky count-discontinuity flag
module count_pwm #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH:0]   i_duty_in,
  input  logic             i_duty_valid,
  output logic             o_duty_ready,
  output logic             o_pwm_out,
  output logic             o_period_start,
  output logic             o_sync_err
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, UPDATE} state_t;
  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_shadow;
  logic [WIDTH:0]   r_active;
  logic [WIDTH-1:0] r_prev_count;
  logic             r_prev_vld;
  logic             w_boundary;
  logic             w_accept;
  logic             w_load;
  logic             w_drive;
  logic             w_pwm;
  logic             w_skip;
  logic [WIDTH:0]   w_clamped;
  logic [WIDTH:0]   w_eff;
  assign w_boundary   = i_count == '0;
  assign o_duty_ready = r_state == IDLE || r_state == RUN;
  assign w_accept     = i_duty_valid && o_duty_ready;
  assign w_clamped    = i_duty_in > FULL ? FULL : i_duty_in;
  assign w_load       = (r_state == ARMED || r_state == UPDATE) && w_boundary;
  assign w_eff        = w_load ? r_shadow : r_active;
  assign w_drive      = r_state == RUN || r_state == UPDATE || w_load;
  assign w_pwm        = w_drive && ({1'b0, i_count} < w_eff);
  assign w_skip       = r_prev_vld && i_count != r_prev_count + WIDTH'(1);
  // Next state: ready states move on an accept, loading states move at the period boundary
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ARMED : IDLE;
      ARMED:   w_next = w_boundary ? RUN : ARMED;
      RUN:     w_next = w_accept ? UPDATE : RUN;
      UPDATE:  w_next = w_boundary ? RUN : UPDATE;
      default: w_next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  // Duty shadow/active registers; a new accept only lands in shadow, so it waits for the next boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_accept) r_shadow <= w_clamped;
      if (w_load)   r_active <= r_shadow;
    end
  end
  // Registered PWM and period-start pulse, one cycle behind the count they were derived from
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_pwm_out      <= 1'b0;
      o_period_start <= 1'b0;
    end else begin
      o_pwm_out      <= w_pwm;
      o_period_start <= w_boundary && (w_next == RUN || w_next == UPDATE);
    end
  end
  // Count continuity tracking; the flag stays set until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_count <= '0;
      r_prev_vld   <= 1'b0;
      o_sync_err   <= 1'b0;
    end else begin
      r_prev_count <= i_count;
      r_prev_vld   <= 1'b1;
      if (w_skip) o_sync_err <= 1'b1;
    end
  end
endmodule
